plic_irq_scheduler: RTL and testbench



---
 rtl/plic_irq_scheduler.sv | 116 +++++++++++
 tb/tb_plic_irq_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_irq_scheduler.sv
// PLIC-style interrupt gateway and priority scheduler: per-source level/edge capture,
// highest-priority arbitration above a hart threshold, and the claim/complete handshake.
module plic_irq_scheduler #(
  parameter int NUM_SOURCES = 32,
  parameter int PRIO_WIDTH  = 3,
  parameter int ID_WIDTH    = $clog2(NUM_SOURCES)
) (
  input  logic                              clock_i,
  input  logic                              reset_ni,
  input  logic [NUM_SOURCES-1:0]            irq_src_i,
  input  logic [NUM_SOURCES-1:0]            edge_sel_i,
  input  logic [NUM_SOURCES-1:0]            enable_i,
  input  logic [NUM_SOURCES*PRIO_WIDTH-1:0] prio_i,
  input  logic [PRIO_WIDTH-1:0]             threshold_i,
  input  logic                              claim_i,
  output logic [ID_WIDTH-1:0]               claim_id_o,
  input  logic                              complete_i,
  input  logic [ID_WIDTH-1:0]               complete_id_i,
  output logic                              ext_irq_o
);

  localparam logic [1:0] GW_IDLE      = 2'd0;
  localparam logic [1:0] GW_PENDING   = 2'd1;
  localparam logic [1:0] GW_INSERVICE = 2'd2;

  // Line 0 is reserved, so per-source state only exists for lines 1..NUM_SOURCES-1.
  logic [1:0]             gw_state_q [NUM_SOURCES-1:1];
  logic [1:0]             gw_state_d [NUM_SOURCES-1:1];
  logic [NUM_SOURCES-1:1] prev_q;
  logic [NUM_SOURCES-1:1] edge_seen_q;
  logic [NUM_SOURCES-1:1] edge_seen_d;
  logic [NUM_SOURCES-1:1] rise;
  logic [NUM_SOURCES-1:1] trigger;

  logic [ID_WIDTH-1:0]    best_id_q;
  logic                   ext_irq_q;
  logic [ID_WIDTH-1:0]    arb_id;
  logic [PRIO_WIDTH-1:0]  arb_prio;
  logic [ID_WIDTH-1:0]    best_id_d;
  logic                   claim_valid;
  logic                   unused_line0;

  assign unused_line0 = ^{irq_src_i[0], edge_sel_i[0], enable_i[0], prio_i[PRIO_WIDTH-1:0]};

  assign claim_valid = claim_i && (best_id_q != '0);

  always_comb begin
    rise    = '0;
    trigger = '0;
    for (int k = 1; k < NUM_SOURCES; k++) begin
      rise[k]    = irq_src_i[k] & ~prev_q[k];
      trigger[k] = edge_sel_i[k] ? rise[k] : irq_src_i[k];
    end
  end

  always_comb begin
    for (int k = 1; k < NUM_SOURCES; k++) begin
      gw_state_d[k]  = gw_state_q[k];
      edge_seen_d[k] = edge_seen_q[k];
      case (gw_state_q[k])
        GW_IDLE: begin
          if (trigger[k]) gw_state_d[k] = GW_PENDING;
        end
        GW_PENDING: begin
          // Further edges while pending are merged into the one outstanding request.
          if (claim_valid && (best_id_q == ID_WIDTH'(k))) gw_state_d[k] = GW_INSERVICE;
        end
        GW_INSERVICE: begin
          if (complete_i && (complete_id_i == ID_WIDTH'(k))) begin
            gw_state_d[k]  = (edge_sel_i[k] && (edge_seen_q[k] || rise[k])) ? GW_PENDING : GW_IDLE;
            edge_seen_d[k] = 1'b0;
          end else if (edge_sel_i[k] && rise[k]) begin
            edge_seen_d[k] = 1'b1;
          end
        end
        default: gw_state_d[k] = GW_IDLE;
      endcase
    end
  end

  // Strict '>' on an ascending scan gives ties to the lowest ID; starting at the
  // threshold makes prio <= threshold (and thus prio 0) ineligible.
  always_comb begin
    arb_id   = '0;
    arb_prio = threshold_i;
    for (int k = 1; k < NUM_SOURCES; k++) begin
      if ((gw_state_q[k] == GW_PENDING) && enable_i[k] &&
          (prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > arb_prio)) begin
        arb_prio = prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
        arb_id   = ID_WIDTH'(k);
      end
    end
  end

  assign best_id_d = claim_valid ? '0 : arb_id;

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      for (int k = 1; k < NUM_SOURCES; k++) gw_state_q[k] <= GW_IDLE;
      prev_q      <= '0;
      edge_seen_q <= '0;
      best_id_q   <= '0;
      ext_irq_q   <= 1'b0;
    end else begin
      for (int k = 1; k < NUM_SOURCES; k++) gw_state_q[k] <= gw_state_d[k];
      prev_q      <= irq_src_i[NUM_SOURCES-1:1];
      edge_seen_q <= edge_seen_d;
      best_id_q   <= best_id_d;
      ext_irq_q   <= (best_id_d != '0);
    end
  end

  assign claim_id_o = best_id_q;
  assign ext_irq_o  = ext_irq_q;

endmodule

// File: tb/tb_plic_irq_scheduler.sv
// Bench for plic_irq_scheduler: a per-cycle reference model fills a scoreboard that a
// negedge monitor drains, plus directed checks of the interrupt scenarios.
module tb_plic_irq_scheduler;

  localparam int NS = 32;
  localparam int PW = 3;
  localparam int IW = 5;

  logic          clock = 1'b0;
  logic          reset_ni = 1'b0;
  logic [NS-1:0] irq_src = '0;
  logic [NS-1:0] edge_sel = '0;
  logic [NS-1:0] enable = '0;
  logic [NS*PW-1:0] prio = '0;
  logic [PW-1:0] threshold = '0;
  logic          claim = 1'b0;
  logic [IW-1:0] claim_id;
  logic          complete = 1'b0;
  logic [IW-1:0] complete_id = '0;
  logic          ext_irq;

  int checks = 0;
  int errors = 0;

  typedef struct { int id; bit irq; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: pending / in-service flags per line plus the registered winner.
  bit m_pend[NS];
  bit m_insvc[NS];
  bit m_seen[NS];
  bit m_prev[NS];
  int m_best;

  plic_irq_scheduler #(.NUM_SOURCES(NS), .PRIO_WIDTH(PW)) dut (
    .clock_i(clock), .reset_ni(reset_ni), .irq_src_i(irq_src), .edge_sel_i(edge_sel),
    .enable_i(enable), .prio_i(prio), .threshold_i(threshold), .claim_i(claim),
    .claim_id_o(claim_id), .complete_i(complete), .complete_id_i(complete_id),
    .ext_irq_o(ext_irq)
  );

  always #5 clock = ~clock;

  function automatic int prio_of(int k);
    return int'(prio[k*PW +: PW]);
  endfunction

  function automatic bit eligible(int k);
    return m_pend[k] && enable[k] && (prio_of(k) > int'(threshold));
  endfunction

  task automatic set_prio(int k, int p);
    prio[k*PW +: PW] = PW'(p);
  endtask

  task automatic model_step();
    int maxp, cand, claimed, cid;
    bit rise;
    exp_t e;
    if (!reset_ni) begin
      for (int k = 0; k < NS; k++) begin
        m_pend[k] = 0; m_insvc[k] = 0; m_seen[k] = 0; m_prev[k] = 0;
      end
      m_best = 0;
    end else begin
      maxp = -1;
      for (int k = 1; k < NS; k++)
        if (eligible(k) && prio_of(k) > maxp) maxp = prio_of(k);
      cand = 0;
      for (int k = NS-1; k >= 1; k--)
        if (eligible(k) && prio_of(k) == maxp) cand = k;
      claimed = (claim && m_best != 0) ? m_best : 0;
      cid = complete ? int'(complete_id) : -1;
      for (int k = 1; k < NS; k++) begin
        rise = irq_src[k] && !m_prev[k];
        if (m_pend[k]) begin
          if (k == claimed) begin m_pend[k] = 0; m_insvc[k] = 1; end
        end else if (m_insvc[k]) begin
          if (k == cid) begin
            m_insvc[k] = 0;
            m_pend[k]  = edge_sel[k] && (m_seen[k] || rise);
            m_seen[k]  = 0;
          end else if (edge_sel[k] && rise) begin
            m_seen[k] = 1;
          end
        end else begin
          m_pend[k] = edge_sel[k] ? rise : irq_src[k];
        end
        m_prev[k] = irq_src[k];
      end
      m_best = (claimed != 0) ? 0 : cand;
    end
    e.id = m_best;
    e.irq = (m_best != 0);
    sb.push_back(e);
  endtask

  // One clock: the model consumes the inputs the DUT sampled, then inputs may change off-edge.
  task automatic applyStimulus();
    @(posedge clock);
    model_step();
    #2;
  endtask

  task automatic checkOutput(bit exp_irq, int exp_id, string name);
    checks++;
    if (ext_irq !== exp_irq || claim_id !== IW'(exp_id)) begin
      errors++;
      $display("[TB] FAIL %s: got irq=%0b id=%0d, expected irq=%0b id=%0d",
               name, ext_irq, claim_id, exp_irq, exp_id);
    end
  endtask

  task automatic do_claim();
    claim = 1'b1; applyStimulus(); claim = 1'b0;
  endtask

  task automatic do_complete(int id);
    complete = 1'b1; complete_id = IW'(id); applyStimulus(); complete = 1'b0;
  endtask

  task automatic do_reset();
    irq_src = '0; edge_sel = '0; enable = '0; prio = '0; threshold = '0;
    claim = 1'b0; complete = 1'b0;
    reset_ni = 1'b0; applyStimulus(); applyStimulus(); reset_ni = 1'b1;
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (claim_id !== IW'(mon_e.id) || ext_irq !== mon_e.irq) begin
        errors++;
        $display("[TB] FAIL scoreboard @%0t: got irq=%0b id=%0d, expected irq=%0b id=%0d",
                 $time, ext_irq, claim_id, mon_e.irq, mon_e.id);
      end
    end
  end

  initial begin
    int ids[$];
    do_reset();
    checkOutput(0, 0, "reset_state");

    // Level source UART
    set_prio(4, 3); enable[4] = 1'b1; irq_src[4] = 1'b1;
    applyStimulus(); applyStimulus();
    checkOutput(1, 4, "uart_raise");
    do_claim();
    checkOutput(0, 0, "uart_claimed");
    do_complete(4); applyStimulus(); applyStimulus();
    checkOutput(1, 4, "uart_repend");
    irq_src[4] = 1'b0;
    do_claim(); do_complete(4); applyStimulus(); applyStimulus(); applyStimulus();
    checkOutput(0, 0, "uart_low_idle");

    // Priority and tie-break
    do_reset();
    set_prio(2, 2); set_prio(3, 5); set_prio(6, 5);
    enable[2] = 1'b1; enable[3] = 1'b1; enable[6] = 1'b1;
    irq_src[2] = 1'b1; irq_src[3] = 1'b1; irq_src[6] = 1'b1;
    applyStimulus();
    irq_src = '0;
    applyStimulus();
    checkOutput(1, 3, "prio_first");
    do_claim(); do_complete(3);
    checkOutput(1, 6, "prio_tie");
    do_claim(); do_complete(6);
    checkOutput(1, 2, "prio_low");
    do_claim(); do_complete(2);
    checkOutput(0, 0, "prio_none");

    // Threshold and enable
    do_reset();
    set_prio(1, 2); threshold = 3'd2; enable[1] = 1'b1; irq_src[1] = 1'b1;
    applyStimulus(); applyStimulus(); applyStimulus();
    checkOutput(0, 0, "thr_blocked");
    threshold = 3'd1; applyStimulus();
    checkOutput(1, 1, "thr_lowered");
    enable[1] = 1'b0; applyStimulus();
    checkOutput(0, 0, "enable_off");
    enable[1] = 1'b1; applyStimulus();
    checkOutput(1, 1, "enable_on");
    irq_src[1] = 1'b0; do_claim(); do_complete(1); threshold = '0;

    // Edge source HLS
    do_reset();
    edge_sel[5] = 1'b1; set_prio(5, 4); enable[5] = 1'b1;
    irq_src[5] = 1'b1; applyStimulus(); irq_src[5] = 1'b0; applyStimulus();
    irq_src[5] = 1'b1; applyStimulus(); irq_src[5] = 1'b0; applyStimulus();
    checkOutput(1, 5, "edge_pending");
    do_claim();
    checkOutput(0, 0, "edge_claimed");
    irq_src[5] = 1'b1; applyStimulus(); irq_src[5] = 1'b0; applyStimulus();
    checkOutput(0, 0, "edge_inservice");
    do_complete(5); applyStimulus();
    checkOutput(1, 5, "edge_replay");
    do_claim(); do_complete(5); applyStimulus(); applyStimulus();
    checkOutput(0, 0, "edge_done");

    // Handshake corners
    do_reset();
    set_prio(2, 2); set_prio(3, 5); enable[2] = 1'b1; enable[3] = 1'b1;
    irq_src[2] = 1'b1; irq_src[3] = 1'b1; applyStimulus();
    irq_src = '0; applyStimulus();
    checkOutput(1, 3, "b2b_setup");
    do_claim(); do_claim();
    checkOutput(1, 2, "b2b_second_noop");
    do_complete(0); do_complete(7); do_complete(31);
    checkOutput(1, 2, "bad_completes");
    claim = 1'b1; do_complete(3); claim = 1'b0;
    applyStimulus();
    checkOutput(0, 0, "claim2_complete3");
    irq_src[3] = 1'b1; applyStimulus(); irq_src[3] = 1'b0; applyStimulus();
    checkOutput(1, 3, "src3_repend");
    claim = 1'b1; do_complete(2); claim = 1'b0;
    applyStimulus();
    checkOutput(0, 0, "claim3_complete2");
    irq_src[2] = 1'b1; applyStimulus(); irq_src[2] = 1'b0; applyStimulus();
    checkOutput(1, 2, "src2_was_completed");

    // Reset mid-operation (2 pending, 3 in service)
    set_prio(4, 6); enable[4] = 1'b1; irq_src[4] = 1'b1;
    reset_ni = 1'b0; applyStimulus();
    checkOutput(0, 0, "reset_mid");
    reset_ni = 1'b1; irq_src = '0;
    applyStimulus(); applyStimulus(); applyStimulus(); applyStimulus();
    checkOutput(0, 0, "no_spurious");

    // Randomized traffic against the model
    do_reset();
    edge_sel = NS'($urandom);
    enable = NS'($urandom) | NS'($urandom);
    for (int k = 0; k < NS; k++) set_prio(k, $urandom_range(0, 7));
    threshold = PW'($urandom_range(0, 3));
    for (int c = 0; c < 3000; c++) begin
      for (int k = 1; k < NS; k++)
        if ($urandom_range(0, 15) == 0) irq_src[k] = ~irq_src[k];
      if ($urandom_range(0, 63) == 0) threshold = PW'($urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0) enable[$urandom_range(1, NS-1)] ^= 1'b1;
      claim = ($urandom_range(0, 3) == 0);
      complete = ($urandom_range(0, 3) == 0);
      ids.delete();
      for (int k = 1; k < NS; k++) if (m_insvc[k]) ids.push_back(k);
      if (ids.size() > 0 && $urandom_range(0, 3) != 0)
        complete_id = IW'(ids[$urandom_range(0, ids.size()-1)]);
      else
        complete_id = IW'($urandom_range(0, NS-1));
      reset_ni = ($urandom_range(0, 499) != 0);
      applyStimulus();
    end
    claim = 1'b0; complete = 1'b0; reset_ni = 1'b1;
    applyStimulus();
    @(negedge clock); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
